// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the two-port cache request arbiter.
package cache_arb_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StResp  = 2'd2
    } state_e;

    localparam logic PORT_IFETCH = 1'b0;
    localparam logic PORT_LSU    = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a sole requester wins, a tie goes to the port
// that did not win last time.
module rr_arbiter2
    import cache_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant,
    output logic       any_grant
);

    always_comb begin
        any_grant = |valid;
        grant     = PORT_IFETCH;
        unique case (valid)
            2'b01:   grant = PORT_IFETCH;
            2'b10:   grant = PORT_LSU;
            2'b11:   grant = ~last_grant;
            default: grant = PORT_IFETCH;
        endcase
    end

endmodule

// File: rtl/cache_port_arbiter.sv
// Shares the single Cache port between instruction fetch (port 0) and
// load/store (port 1); one access in flight, stall watchdog.
module cache_port_arbiter
    import cache_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned STALL_MAX = 64
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,

    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,

    output logic              Mem_read,
    output logic              Mem_write,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] Data_in,
    input  logic              Stall,
    input  logic [DATA_W-1:0] Data_out,

    output logic              err
);

    localparam int unsigned     CNT_W      = $clog2(STALL_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(STALL_MAX);
    localparam logic [CNT_W-1:0] CNT_MAX_M1 = CNT_W'(STALL_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_e              state_q;
    logic                last_grant_q;
    logic                cmd_id_q;
    logic                cmd_we_q;
    logic [ADDR_W-1:0]   cmd_addr_q;
    logic [DATA_W-1:0]   cmd_wdata_q;
    logic                mem_read_q;
    logic                mem_write_q;
    logic [CNT_W-1:0]    stall_cnt_q;
    logic                err_q;
    logic                rsp0_valid_q;
    logic                rsp1_valid_q;
    logic [DATA_W-1:0]   rdata0_q;
    logic [DATA_W-1:0]   rdata1_q;

    logic                grant;
    logic                any_grant;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [DATA_W-1:0]   cap_data;

    rr_arbiter2 u_rr (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant_q),
        .grant      (grant),
        .any_grant  (any_grant)
    );

    always_comb begin
        sel_we    = (grant == PORT_LSU) ? req1_we    : req0_we;
        sel_addr  = (grant == PORT_LSU) ? req1_addr  : req0_addr;
        sel_wdata = (grant == PORT_LSU) ? req1_wdata : req0_wdata;
        cap_data  = cmd_we_q ? '0 : Data_out;
    end

    // Ready is combinational so the requester sees acceptance in the grant cycle.
    always_comb begin
        req0_ready = (state_q == StIdle) && any_grant && (grant == PORT_IFETCH);
        req1_ready = (state_q == StIdle) && any_grant && (grant == PORT_LSU);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            last_grant_q <= PORT_LSU;
            cmd_id_q     <= PORT_IFETCH;
            cmd_we_q     <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_wdata_q  <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            stall_cnt_q  <= '0;
            err_q        <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (any_grant) begin
                        cmd_id_q     <= grant;
                        cmd_we_q     <= sel_we;
                        cmd_addr_q   <= sel_addr;
                        cmd_wdata_q  <= sel_wdata;
                        last_grant_q <= grant;
                        mem_read_q   <= ~sel_we;
                        mem_write_q  <= sel_we;
                        state_q      <= StIssue;
                    end
                end
                StIssue: begin
                    if (!Stall) begin
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        if (cmd_id_q == PORT_LSU) begin
                            rdata1_q     <= cap_data;
                            rsp1_valid_q <= 1'b1;
                        end else begin
                            rdata0_q     <= cap_data;
                            rsp0_valid_q <= 1'b1;
                        end
                        state_q <= StResp;
                    end else begin
                        if (stall_cnt_q != CNT_MAX) begin
                            stall_cnt_q <= stall_cnt_q + CNT_ONE;
                        end
                        // Flag raised on the edge that completes the STALL_MAX-th stall cycle.
                        if (stall_cnt_q == CNT_MAX_M1) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                StResp: begin
                    stall_cnt_q <= '0;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign Mem_read   = mem_read_q;
    assign Mem_write  = mem_write_q;
    assign Address    = cmd_addr_q;
    assign Data_in    = cmd_wdata_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_rdata = rdata0_q;
    assign rsp1_rdata = rdata1_q;
    assign err        = err_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Self-checking bench for cache_port_arbiter: directed scenarios plus a
// randomized transaction-level model of grants, latency and returned data.
module tb_cache_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_we, req0_ready, rsp0_valid;
    logic [9:0]  req0_addr;
    logic [31:0] req0_wdata, rsp0_rdata;
    logic        req1_valid, req1_we, req1_ready, rsp1_valid;
    logic [9:0]  req1_addr;
    logic [31:0] req1_wdata, rsp1_rdata;
    logic        Mem_read, Mem_write, Stall, err;
    logic [9:0]  Address;
    logic [31:0] Data_in, Data_out;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic        m_last;
    logic [31:0] m_rdata [2];

    cache_port_arbiter #(.ADDR_W(10), .DATA_W(32), .STALL_MAX(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_we    (req0_we),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req0_ready (req0_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_rdata (rsp0_rdata),
        .req1_valid (req1_valid),
        .req1_we    (req1_we),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .req1_ready (req1_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_rdata (rsp1_rdata),
        .Mem_read   (Mem_read),
        .Mem_write  (Mem_write),
        .Address    (Address),
        .Data_in    (Data_in),
        .Stall      (Stall),
        .Data_out   (Data_out),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        req0_valid = 0; req0_we = 0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 0; req1_we = 0; req1_addr = '0; req1_wdata = '0;
        Stall = 0; Data_out = '0;
        @(negedge clk);
        n_tests++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, Mem_read, Mem_write, err,
             Address, Data_in, rsp0_rdata, rsp1_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got cmd=%b/%h/%h rsp=%b%b err=%b, want all 0",
                     {Mem_read, Mem_write}, Address, Data_in, rsp0_valid, rsp1_valid, err);
        end
        tick;
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({req1_ready, req0_ready, Mem_read, Mem_write, err} !== 5'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %b, want 00000",
                     {req1_ready, req0_ready, Mem_read, Mem_write, err});
        end
        tick;
        m_last = 1'b1;
        m_rdata[0] = '0;
        m_rdata[1] = '0;
    endtask

    task automatic test_read_hit;
        req0_valid = 1; req0_we = 0; req0_addr = 10'h024; req0_wdata = '0;
        Stall = 0; Data_out = 32'hDEADBEEF;
        @(negedge clk);
        n_tests++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL hit_ready: got %b, want 01", {req1_ready, req0_ready});
        end
        tick;
        req0_valid = 0;
        @(negedge clk);
        n_tests++;
        if ({Mem_read, Mem_write, Address} !== {1'b1, 1'b0, 10'h024}) begin
            n_fail++;
            $display("FAIL hit_issue: got rd=%b wr=%b addr=%h, want 1 0 024",
                     Mem_read, Mem_write, Address);
        end
        tick;
        Data_out = 32'h0BAD0BAD;
        @(negedge clk);
        n_tests++;
        if ({rsp1_valid, rsp0_valid, Mem_read, rsp0_rdata} !== {3'b010, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL hit_resp: got v=%b%b rd=%b data=%h, want 01 0 deadbeef",
                     rsp1_valid, rsp0_valid, Mem_read, rsp0_rdata);
        end
        tick;
        @(negedge clk);
        n_tests++;
        if ({rsp0_valid, rsp0_rdata} !== {1'b0, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL hit_hold: got v=%b data=%h, want 0 deadbeef", rsp0_valid, rsp0_rdata);
        end
        tick;
        m_last = 1'b0;
        m_rdata[0] = 32'hDEADBEEF;
    endtask

    task automatic test_miss_write;
        req1_valid = 1; req1_we = 1; req1_addr = 10'h3F0; req1_wdata = 32'h12345678;
        @(negedge clk);
        n_tests++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL miss_ready: got %b, want 10", {req1_ready, req0_ready});
        end
        tick;
        req1_valid = 0;
        for (int i = 0; i < 6; i++) begin
            Stall = (i < 5);
            Data_out = $urandom;
            @(negedge clk);
            n_tests++;
            if ({Mem_read, Mem_write, Address, Data_in} !== {2'b01, 10'h3F0, 32'h12345678}) begin
                n_fail++;
                $display("FAIL miss_cmd_cycle%0d: got %b%b %h %h, want 01 3f0 12345678",
                         i, Mem_read, Mem_write, Address, Data_in);
            end
            tick;
        end
        Stall = 0;
        @(negedge clk);
        n_tests++;
        if ({rsp1_valid, rsp0_valid, Mem_write, err, rsp1_rdata} !== {4'b1000, 32'h0}) begin
            n_fail++;
            $display("FAIL miss_resp: got v=%b%b wr=%b err=%b data=%h, want 10 0 0 0",
                     rsp1_valid, rsp0_valid, Mem_write, err, rsp1_rdata);
        end
        tick;
        m_last = 1'b1;
        m_rdata[1] = '0;
    endtask

    task automatic test_contention;
        logic        w;
        logic [31:0] d;
        req0_valid = 1; req0_we = 0; req0_addr = 10'h011;
        req1_valid = 1; req1_we = 0; req1_addr = 10'h222;
        for (int k = 0; k < 4; k++) begin
            w = ~m_last;
            @(negedge clk);
            n_tests++;
            if ({rsp1_valid, rsp0_valid, req1_ready, req0_ready} !== {2'b00, w, ~w}) begin
                n_fail++;
                $display("FAIL contend_grant%0d: got rsp=%b%b rdy=%b%b, want port %0d",
                         k, rsp1_valid, rsp0_valid, req1_ready, req0_ready, w);
            end
            tick;
            d = $urandom;
            Data_out = d;
            @(negedge clk);
            n_tests++;
            if ({req1_ready, req0_ready, Mem_read, Address} !==
                {3'b001, (w ? 10'h222 : 10'h011)}) begin
                n_fail++;
                $display("FAIL contend_issue%0d: got rdy=%b%b rd=%b addr=%h",
                         k, req1_ready, req0_ready, Mem_read, Address);
            end
            tick;
            m_rdata[w] = d;
            m_last = w;
            if (k == 3) begin
                req0_valid = 0;
                req1_valid = 0;
            end
            @(negedge clk);
            n_tests++;
            if ({rsp1_valid, rsp0_valid, rsp1_rdata, rsp0_rdata} !==
                {w, ~w, m_rdata[1], m_rdata[0]}) begin
                n_fail++;
                $display("FAIL contend_resp%0d: got v=%b%b d1=%h d0=%h, want port %0d data %h",
                         k, rsp1_valid, rsp0_valid, rsp1_rdata, rsp0_rdata, w, d);
            end
            tick;
        end
    endtask

    task automatic test_withdrawn;
        req0_valid = 1; req0_we = 0; req0_addr = 10'h0C3; req0_wdata = 32'h5;
        Stall = 1;
        @(negedge clk);
        n_tests++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL wd_ready0: got %b, want 01", {req1_ready, req0_ready});
        end
        tick;
        req0_valid = 0;
        req1_valid = 1; req1_we = 1; req1_addr = 10'h155; req1_wdata = 32'hCAFE;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) req1_valid = 0;
            Stall = (i < 2);
            Data_out = 32'h77;
            @(negedge clk);
            n_tests++;
            if ({req1_ready, Mem_read, Mem_write, Address} !== {3'b010, 10'h0C3}) begin
                n_fail++;
                $display("FAIL wd_issue%0d: got rdy1=%b rd=%b wr=%b addr=%h, want 0 1 0 0c3",
                         i, req1_ready, Mem_read, Mem_write, Address);
            end
            tick;
        end
        Stall = 0;
        tick;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if ({req1_ready, rsp1_valid, Mem_read, Mem_write} !== 4'b0) begin
                n_fail++;
                $display("FAIL wd_idle%0d: got rdy1=%b rsp1=%b rd=%b wr=%b, want 0000",
                         i, req1_ready, rsp1_valid, Mem_read, Mem_write);
            end
            tick;
        end
        m_last = 1'b0;
        m_rdata[0] = 32'h77;
    endtask

    task automatic test_random;
        logic        pend [2];
        logic        pwe [2];
        logic [9:0]  paddr [2];
        logic [31:0] pwd [2];
        logic        w;
        int          s;
        logic [31:0] last_do;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 0; pwe[p] = 0; paddr[p] = '0; pwd[p] = '0;
        end
        for (int it = 0; it < 60; it++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && ($urandom_range(1, 0) == 1)) begin
                    pend[p] = 1; pwe[p] = 1'($urandom_range(1, 0));
                    paddr[p] = 10'($urandom); pwd[p] = $urandom;
                end else if (pend[p] && ($urandom_range(7, 0) == 0)) begin
                    pend[p] = 0;
                end
            end
            req0_valid = pend[0]; req0_we = pwe[0]; req0_addr = paddr[0]; req0_wdata = pwd[0];
            req1_valid = pend[1]; req1_we = pwe[1]; req1_addr = paddr[1]; req1_wdata = pwd[1];
            Stall = 0;
            @(negedge clk);
            if (!pend[0] && !pend[1]) begin
                n_tests++;
                if ({req1_ready, req0_ready, Mem_read, Mem_write} !== 4'b0) begin
                    n_fail++;
                    $display("FAIL rand_idle%0d: got %b, want 0000",
                             it, {req1_ready, req0_ready, Mem_read, Mem_write});
                end
                tick;
                continue;
            end
            w = (pend[0] && pend[1]) ? ~m_last : pend[1];
            n_tests++;
            if ({rsp1_valid, rsp0_valid, req1_ready, req0_ready} !== {2'b00, w, ~w}) begin
                n_fail++;
                $display("FAIL rand_grant%0d: got rsp=%b%b rdy=%b%b, want port %0d",
                         it, rsp1_valid, rsp0_valid, req1_ready, req0_ready, w);
            end
            tick;
            pend[w] = 0;
            req0_valid = pend[0];
            req1_valid = pend[1];
            s = $urandom_range(4, 0);
            last_do = '0;
            for (int i = 0; i <= s; i++) begin
                Stall = (i < s);
                last_do = $urandom;
                Data_out = last_do;
                @(negedge clk);
                n_tests++;
                if ({req1_ready, req0_ready, Mem_read, Mem_write, Address, Data_in} !==
                    {2'b00, ~pwe[w], pwe[w], paddr[w], pwd[w]}) begin
                    n_fail++;
                    $display("FAIL rand_cmd%0d.%0d: got rdy=%b%b %b%b %h %h, want %b%b %h %h",
                             it, i, req1_ready, req0_ready, Mem_read, Mem_write, Address,
                             Data_in, ~pwe[w], pwe[w], paddr[w], pwd[w]);
                end
                tick;
            end
            Stall = 0;
            Data_out = $urandom;
            m_rdata[w] = pwe[w] ? 32'h0 : last_do;
            m_last = w;
            @(negedge clk);
            n_tests++;
            if ({rsp1_valid, rsp0_valid, Mem_read, Mem_write, rsp1_rdata, rsp0_rdata} !==
                {w, ~w, 2'b00, m_rdata[1], m_rdata[0]}) begin
                n_fail++;
                $display("FAIL rand_resp%0d: got v=%b%b d1=%h d0=%h, want port %0d d1=%h d0=%h",
                         it, rsp1_valid, rsp0_valid, rsp1_rdata, rsp0_rdata, w,
                         m_rdata[1], m_rdata[0]);
            end
            tick;
        end
        req0_valid = 0;
        req1_valid = 0;
        tick;
    endtask

    task automatic test_watchdog;
        logic [31:0] d;
        d = '0;
        req0_valid = 1; req0_we = 0; req0_addr = 10'h155; req0_wdata = 32'h1;
        @(negedge clk);
        n_tests++;
        if ({req1_ready, req0_ready, err} !== 3'b010) begin
            n_fail++;
            $display("FAIL wdog_ready: got rdy=%b%b err=%b, want 01 0",
                     req1_ready, req0_ready, err);
        end
        tick;
        req0_valid = 0;
        for (int i = 0; i < 11; i++) begin
            Stall = (i < 10);
            d = $urandom;
            Data_out = d;
            @(negedge clk);
            n_tests++;
            if ({Mem_read, Address, err} !== {1'b1, 10'h155, (i >= 8)}) begin
                n_fail++;
                $display("FAIL wdog_cycle%0d: got rd=%b addr=%h err=%b, want 1 155 %b",
                         i, Mem_read, Address, err, (i >= 8));
            end
            tick;
        end
        Stall = 0;
        @(negedge clk);
        n_tests++;
        if ({rsp0_valid, err, rsp0_rdata} !== {2'b11, d}) begin
            n_fail++;
            $display("FAIL wdog_resp: got v=%b err=%b data=%h, want 1 1 %h",
                     rsp0_valid, err, rsp0_rdata, d);
        end
        tick;
        tick;
        @(negedge clk);
        n_tests++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL wdog_sticky: got err=%b, want 1", err);
        end
        tick;
        m_last = 1'b0;
        m_rdata[0] = d;
    endtask

    task automatic test_reset_mid_issue;
        req0_valid = 1; req0_we = 0; req0_addr = 10'h0AA; req0_wdata = 32'h99;
        Stall = 1;
        @(negedge clk);
        tick;
        req0_valid = 0;
        @(negedge clk);
        n_tests++;
        if ({Mem_read, Address} !== {1'b1, 10'h0AA}) begin
            n_fail++;
            $display("FAIL rst_pre: got rd=%b addr=%h, want 1 0aa", Mem_read, Address);
        end
        #2;
        reset = 1'b0;
        #1;
        n_tests++;
        if ({Mem_read, Mem_write, Address, Data_in, err} !== '0) begin
            n_fail++;
            $display("FAIL rst_async: got rd=%b wr=%b addr=%h din=%h err=%b, want all 0",
                     Mem_read, Mem_write, Address, Data_in, err);
        end
        tick;
        tick;
        reset = 1'b1;
        Stall = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++;
            if ({rsp1_valid, rsp0_valid, Mem_read, Mem_write} !== 4'b0) begin
                n_fail++;
                $display("FAIL rst_no_rsp%0d: got rsp=%b%b rd=%b wr=%b, want 0000",
                         i, rsp1_valid, rsp0_valid, Mem_read, Mem_write);
            end
            tick;
        end
        req0_valid = 1; req1_valid = 1;
        @(negedge clk);
        n_tests++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL rst_tie: got %b, want 01", {req1_ready, req0_ready});
        end
        tick;
        req0_valid = 0; req1_valid = 0;
        tick;
        tick;
        tick;
    endtask

    initial begin
        test_reset;
        test_read_hit;
        test_miss_write;
        test_contention;
        test_withdrawn;
        test_random;
        test_watchdog;
        test_reset_mid_issue;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
